// File: rtl/icache.sv
// Direct-mapped instruction cache: 32-byte lines, zero-latency hits, single
// outstanding line fill to memory, fence.i-style invalidate-all.
module icache #(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic [31:0]  mem_address,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  input  logic         inv,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned OFS_W  = 5;
  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W  = 32 - OFS_W - IDX_W;
  localparam int unsigned LA_W   = 32 - OFS_W;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Per-set storage; only the valid bits carry reset.
  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];

  // Line address (bits [31:5]) of the fill in flight.
  logic [LA_W-1:0]     line_addr;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [2:0]          req_word;
  logic [TAG_W-1:0]    fill_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [LINE_W-1:0]   rd_line;
  logic                lookup_hit;
  logic                line_load;
  logic                fill_done;
  logic                unused_byte_sel;

  assign req_tag  = mem_address[31 -: TAG_W];
  assign req_idx  = mem_address[OFS_W +: IDX_W];
  assign req_word = mem_address[4:2];

  assign fill_tag = line_addr[LA_W-1 -: TAG_W];
  assign fill_idx = line_addr[0 +: IDX_W];

  // Instruction fetch is word-granular; the byte select is not needed.
  assign unused_byte_sel = ^mem_address[1:0];

  assign rd_line    = data_mem[req_idx];
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign mem_rdata  = rd_line[{req_word, 5'b00000} +: WORD_W];

  assign pmem_address = {line_addr, 5'b00000};

  // State register; reset abandons any fill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and response decode; hits answer in the lookup cycle.
  always_comb begin
    state_next = state;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    line_load  = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read) begin
          if (lookup_hit) begin
            mem_resp = 1'b1;
          end else begin
            line_load  = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the missing line address; held constant for the whole fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_addr <= '0;
    end else if (line_load) begin
      line_addr <= mem_address[31:OFS_W];
    end
  end

  // Valid bits: invalidate-all wins over a completing fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (inv) begin
      valid <= '0;
    end else if (fill_done) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are written on fill completion, even under invalidate.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache (NUM_SETS=8): scoreboard of expected fetch
// words, checked with immediate assertions against a simple memory model.
module tb_icache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         inv;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  icache #(.NUM_SETS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .inv          (inv),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  // Memory contents: word at 0x64 is the known instruction, the rest hashed.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0064) return 32'h00A0_0093;
    return (w * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [255:0] make_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = word_at(la + 32'(4*w));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected fetch word and compare with mem_rdata.
  task automatic chk_data(input string tag);
    logic [31:0] exp;
    exp = 32'hxxxx_xxxx;
    if (sb.size() > 0) exp = sb.pop_front();
    chk(tag, mem_rdata, exp);
  endtask

  task automatic do_hit(input logic [31:0] a);
    string t;
    t = $sformatf("%h", a);
    @(negedge clk);
    mem_read = 1'b1; mem_address = a; sb.push_back(word_at(a));
    #1;
    chk({"hit_resp_", t}, 32'(mem_resp), 32'd1);
    chk({"hit_no_fill_", t}, 32'(pmem_read), 32'd0);
    chk_data({"hit_data_", t});
  endtask

  // mode: 0 plain, 1 drop mem_read mid-fill, 2 inv with pmem_resp, 3 inv mid-fill
  task automatic do_miss(input logic [31:0] a, input logic [31:0] la, input int mode);
    string t;
    t = $sformatf("%h", a);
    @(negedge clk);
    mem_read = 1'b1; mem_address = a; sb.push_back(word_at(a));
    #1;
    chk({"miss_lookup_", t}, 32'(mem_resp), 32'd0);
    @(negedge clk); #1;
    chk({"fill_req_", t}, 32'(pmem_read), 32'd1);
    chk({"fill_addr_", t}, pmem_address, la);
    chk({"fill_no_resp_", t}, 32'(mem_resp), 32'd0);
    if (mode == 1) mem_read = 1'b0;
    if (mode == 3) inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    #1;
    chk({"fill_hold_", t}, pmem_address, la);
    chk({"fill_req_hold_", t}, 32'(pmem_read), 32'd1);
    pmem_rdata = make_line(la); pmem_resp = 1'b1;
    if (mode == 2) inv = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0; inv = 1'b0; mem_read = 1'b1;
    #1;
    chk({"fill_done_", t}, 32'(pmem_read), 32'd0);
    if (mode == 2) begin
      chk({"inv_fill_miss_", t}, 32'(mem_resp), 32'd0);
      @(negedge clk); #1;
      chk({"refill_req_", t}, 32'(pmem_read), 32'd1);
      chk({"refill_addr_", t}, pmem_address, la);
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
    end
    chk({"miss_resp_", t}, 32'(mem_resp), 32'd1);
    chk_data({"miss_data_", t});
  endtask

  // Fetch a, redirect to b during its fill; both fills must complete in order.
  task automatic do_redirect(input logic [31:0] a, input logic [31:0] la,
                             input logic [31:0] b, input logic [31:0] lb);
    @(negedge clk);
    mem_read = 1'b1; mem_address = a;
    #1;
    chk("redir_miss_a", 32'(mem_resp), 32'd0);
    @(negedge clk); #1;
    chk("redir_fill_a_req", 32'(pmem_read), 32'd1);
    chk("redir_fill_a_addr", pmem_address, la);
    mem_address = b;
    #1;
    chk("redir_no_resp", 32'(mem_resp), 32'd0);
    chk("redir_addr_kept", pmem_address, la);
    @(negedge clk); #1;
    chk("redir_addr_hold", pmem_address, la);
    pmem_rdata = make_line(la); pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("redir_idle", 32'(pmem_read), 32'd0);
    chk("redir_miss_b", 32'(mem_resp), 32'd0);
    @(negedge clk); #1;
    chk("redir_fill_b_req", 32'(pmem_read), 32'd1);
    chk("redir_fill_b_addr", pmem_address, lb);
    sb.push_back(word_at(b));
    pmem_rdata = make_line(lb); pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("redir_resp_b", 32'(mem_resp), 32'd1);
    chk_data("redir_data_b");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_address = '0; inv = 1'b0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    #12;
    chk("rst_pmem_read", 32'(pmem_read), 32'd0);
    chk("rst_mem_resp", 32'(mem_resp), 32'd0);
    chk("rst_pmem_addr", pmem_address, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_no_read_resp", 32'(mem_resp), 32'd0);
    chk("idle_no_read_fill", 32'(pmem_read), 32'd0);

    // Cold miss on 0x64 fills line 0x60; word 1 is the known instruction.
    do_miss(32'h64, 32'h60, 0);
    chk("cold_word1", mem_rdata, 32'h00A0_0093);

    // Sequential hits in the same line.
    do_hit(32'h60);
    do_hit(32'h68);
    do_hit(32'h7C);

    // Conflict: 0x160 and 0x60 share index 3.
    do_miss(32'h160, 32'h160, 0);
    do_miss(32'h60, 32'h60, 0);

    // Redirect 0x100 -> 0x200; with 8 sets these share index 0, so 0x100 is evicted.
    do_redirect(32'h100, 32'h100, 32'h200, 32'h200);
    do_miss(32'h100, 32'h100, 0);
    // Redirect between distinct sets: the abandoned fetch's line stays usable.
    do_redirect(32'h344, 32'h340, 32'h180, 32'h180);
    do_hit(32'h344);
    do_hit(32'h104);
    do_hit(32'h188);

    // Fetch dropped mid-fill: the fill still completes.
    do_miss(32'h2A0, 32'h2A0, 1);
    do_hit(32'h2BC);

    // Invalidate coincident with fill completion leaves the line invalid.
    do_miss(32'h40, 32'h40, 2);

    // Invalidate mid-fill: the filled line is valid, earlier lines are not.
    do_miss(32'h3C4, 32'h3C0, 3);
    do_hit(32'h3D8);
    do_miss(32'h40, 32'h40, 0);

    // Invalidate in IDLE still answers the pre-invalidate lookup.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h4C; inv = 1'b1; sb.push_back(word_at(32'h4C));
    #1;
    chk("inv_idle_hit", 32'(mem_resp), 32'd1);
    chk_data("inv_idle_data");
    @(negedge clk);
    inv = 1'b0; mem_read = 1'b0;
    #1;
    chk("inv_idle_quiet", 32'(mem_resp), 32'd0);
    do_miss(32'h3C0, 32'h3C0, 0);
    do_miss(32'h44, 32'h40, 0);

    // Stray pmem_resp in IDLE is ignored.
    @(negedge clk);
    mem_read = 1'b0; pmem_rdata = make_line(32'h500); pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("stray_resp_idle", 32'(pmem_read), 32'd0);
    do_hit(32'h44);

    // Reset mid-fill abandons the fill; a later pmem_resp is ignored.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h404;
    #1;
    chk("rstfill_miss", 32'(mem_resp), 32'd0);
    @(negedge clk); #1;
    chk("rstfill_req", 32'(pmem_read), 32'd1);
    chk("rstfill_addr", pmem_address, 32'h400);
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("rstfill_pmem_read", 32'(pmem_read), 32'd0);
    chk("rstfill_pmem_addr", pmem_address, 32'h0);
    chk("rstfill_mem_resp", 32'(mem_resp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; pmem_rdata = make_line(32'h400); pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("rstfill_late_resp", 32'(pmem_read), 32'd0);
    do_miss(32'h404, 32'h400, 0);
    do_miss(32'h44, 32'h40, 0);

    @(negedge clk);
    mem_read = 1'b0;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
